// File: rtl/lut_pkg.sv
// Shared types for the run-time lookup-table writer: FSM states and the
// response status codes reported on rsp_status.
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] ST_UPDATED  = 2'b00;
  localparam logic [1:0] ST_INSERTED = 2'b01;
  localparam logic [1:0] ST_FULL     = 2'b10;
  localparam logic [1:0] ST_MISS     = 2'b11;

endpackage

// File: rtl/lut_slot.sv
// One table slot: a live bit plus the packed {key,data} pair.
// An empty slot always drives an all-zero pair.
// The key comparator only reports a match for a live slot.
module lut_slot #(
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic                         clr,
  input  logic [KEY_LEN-1:0]           wr_key,
  input  logic [DATA_LEN-1:0]          wr_data,
  input  logic [KEY_LEN-1:0]           cmp_key,
  output logic                         vld,
  output logic [KEY_LEN+DATA_LEN-1:0]  pair,
  output logic                         match
);

  // Slot storage; a clear always wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      pair <= '0;
    end else if (clr) begin
      vld  <= 1'b0;
      pair <= '0;
    end else if (wr) begin
      vld  <= 1'b1;
      pair <= {wr_key, wr_data};
    end
  end

  assign match = vld && (pair[KEY_LEN+DATA_LEN-1 -: KEY_LEN] == cmp_key);

endmodule

// File: rtl/lut_table_writer.sv
// Run-time builder for a packed key/data lookup bus.
// Requests are accepted over valid/ready. Each request then scans every slot,
// one slot per cycle, and commits a single table change.
// The request is sampled at the end of cycle T. The table update and the
// one-cycle rsp_valid pulse are both visible during cycle T+NR_KEY+1.
// The optional macro LUT_WRITER_DELETE_EN enables delete requests via req_del.
//
// state  | meaning
// IDLE   | ready for a request, table stable
// SCAN   | examining slot idx for key hit / lowest free slot
// COMMIT | table just updated, rsp_valid high
module lut_table_writer
  import lut_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8,
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
  localparam int CNT_W    = $clog2(NR_KEY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [KEY_LEN-1:0]           req_key,
  input  logic [DATA_LEN-1:0]          req_data,
  input  logic                         req_del,
  output logic                         rsp_valid,
  output logic [1:0]                   rsp_status,
  output logic [NR_KEY*PAIR_LEN-1:0]   lut,
  output logic [NR_KEY-1:0]            slot_vld,
  output logic [CNT_W-1:0]             count
);

  localparam int IDX_W = $clog2(NR_KEY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx;
  logic                hit, free_found;
  logic [IDX_W-1:0]    hit_idx, free_idx;
  logic [KEY_LEN-1:0]  key_q;
  logic [DATA_LEN-1:0] data_q;
  logic                del_q;

  logic                xfer, last_scan;
  logic                cur_hit, cur_free;
  logic                hit_n, free_n;
  logic [IDX_W-1:0]    hit_idx_n, free_idx_n;
  logic [NR_KEY-1:0]   wr_vec, clr_vec, match_vec;
  logic [1:0]          status_n;
  logic                cnt_inc, cnt_dec;

  // Slot array; the commit strobes come from the decision logic below.
  for (genvar n = 0; n < NR_KEY; n++) begin : g_slot
    lut_slot #(
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_vec[n]),
      .clr     (clr_vec[n]),
      .wr_key  (key_q),
      .wr_data (data_q),
      .cmp_key (key_q),
      .vld     (slot_vld[n]),
      .pair    (lut[PAIR_LEN*n +: PAIR_LEN]),
      .match   (match_vec[n])
    );
  end

  assign req_ready = (state == IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state and the transfer / final-scan strobes.
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    last_scan  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          xfer       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (idx == LAST_IDX) begin
          last_scan  = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fold the slot under examination into the hit / free trackers.
  // The final slot is folded here combinationally so the commit can use it at once.
  always_comb begin
    cur_hit    = match_vec[idx];
    cur_free   = !slot_vld[idx];
    hit_n      = hit | cur_hit;
    hit_idx_n  = cur_hit ? idx : hit_idx;
    free_n     = free_found | cur_free;
    free_idx_n = (cur_free && !free_found) ? idx : free_idx;
  end

`ifdef LUT_WRITER_DELETE_EN
  // Delete requests are recognised.
  always_ff @(posedge clk) begin
    if (rst)       del_q <= 1'b0;
    else if (xfer) del_q <= req_del;
  end
`else
  // Every request is a write, so req_del is deliberately ignored.
  logic unused_del;
  assign unused_del = req_del;
  assign del_q      = 1'b0;
`endif

  // Commit decision: which slot to write or clear, the status code and the count change.
  always_comb begin
    wr_vec   = '0;
    clr_vec  = '0;
    status_n = ST_FULL;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    if (last_scan) begin
      if (del_q) begin
        if (hit_n) begin
          clr_vec[hit_idx_n] = 1'b1;
          status_n           = ST_UPDATED;
          cnt_dec            = 1'b1;
        end else begin
          status_n = ST_MISS;
        end
      end else if (hit_n) begin
        wr_vec[hit_idx_n] = 1'b1;
        status_n          = ST_UPDATED;
      end else if (free_n) begin
        wr_vec[free_idx_n] = 1'b1;
        status_n           = ST_INSERTED;
        cnt_inc            = 1'b1;
      end else begin
        status_n = ST_FULL;
      end
    end
  end

  // Request latch, scan trackers, response and live-entry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      hit        <= 1'b0;
      hit_idx    <= '0;
      free_found <= 1'b0;
      free_idx   <= '0;
      key_q      <= '0;
      data_q     <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_UPDATED;
      count      <= '0;
    end else begin
      rsp_valid <= last_scan;
      if (last_scan) rsp_status <= status_n;
      if (cnt_inc)      count <= count + CNT_W'(1);
      else if (cnt_dec) count <= count - CNT_W'(1);
      if (xfer) begin
        key_q      <= req_key;
        data_q     <= req_data;
        idx        <= '0;
        hit        <= 1'b0;
        free_found <= 1'b0;
      end else if (state == SCAN) begin
        hit        <= hit_n;
        hit_idx    <= hit_idx_n;
        free_found <= free_n;
        free_idx   <= free_idx_n;
        if (!last_scan) idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
